midi_byte_fifo: RTL and testbench
=================================

Name: midi_byte_fifo

Overview:
- Single-clock, first-word-fall-through byte FIFO for MIDI traffic between a port receiver and the router core.
- Instantiates the team's existing dual-port block RAM, which has a 1-cycle registered read and a read-enable.
- The block owns the pointers, the occupancy count, the full/empty flags and the valid/ready handshakes.
- Sustains one push and one pop per cycle.

Parameters:
ADDR_SIZE, 9, RAM address width; storage depth is 2**ADDR_SIZE.
DATA_SIZE, 8, byte width of stored words.
RAM_DEPTH, (1 << ADDR_SIZE), derived; not overridden independently.

Ports:
clk  input  1  single clock; drives both RAM wclk and rclk.
rst_n  input  1  asynchronous, active-low reset.
flush  input  1  synchronous clear of all contents and flags.
in_data  input  DATA_SIZE  byte to enqueue.
in_valid  input  1  producer offers in_data.
in_ready  output  1  FIFO accepts; equals not full.
out_data  output  DATA_SIZE  head byte; driven from RAM rdata.
out_valid  output  1  out_data holds a valid head byte.
out_ready  input  1  consumer takes the head byte.
level  output  ADDR_SIZE+1  bytes held (memory plus head).
overflow  output  1  sticky; push attempted while full.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr and mem_count are 0; out_valid is 0; overflow is 0.
  - in_ready is 1 and level is 0.
  - out_data is don't-care while out_valid is 0.
- push = in_valid & in_ready.
  - RAM we = push, waddr = wr_ptr.
  - wr_ptr wraps modulo RAM_DEPTH.
- pop = out_valid & out_ready.
- Prefetch: fetch = (mem_count != 0) & (!out_valid | pop).
  - RAM re = fetch, raddr = rd_ptr.
  - On fetch, rd_ptr increments (wraps) and out_valid is set next cycle.
  - On pop without fetch, out_valid clears next cycle.
  - RAM re is held low while the head is stalled, so rdata stays stable.
- mem_count (ADDR_SIZE+1 bits):
  - +1 on push only, -1 on fetch only, unchanged on both.
  - Full is mem_count == RAM_DEPTH; in_ready = !full, combinational from a register.
- level = mem_count + out_valid; maximum value is RAM_DEPTH+1.
- Latency:
  - A byte pushed at edge N into an empty FIFO is fetched in cycle N+1.
  - out_valid asserts in cycle N+2.
- Throughput: back-to-back pops with mem_count > 0 produce no bubbles; a fetch is issued in the same cycle as each pop.
- Full:
  - in_valid while full is dropped; RAM and pointers are untouched; overflow sets the next cycle.
  - Push and fetch in the same cycle at full is impossible, because in_ready is low.
- Empty:
  - out_valid is 0 and no re is issued.
  - A push into an empty FIFO never collides with a read of the same address, because fetch requires mem_count != 0.
- Same-address hazard: wr_ptr == rd_ptr with mem_count != 0 only occurs when full, and then writes are blocked.
- flush:
  - Highest priority: the next state equals the reset state, including overflow.
  - A concurrent push or pop that cycle is discarded; RAM contents are not cleared.
- Reset mid-transfer: all state returns to the reset values immediately; any in-flight RAM read result is ignored.

Decomposition:
- Shared MIDI package (constants):
  - MIDI_DATA_SIZE = 8.
  - MIDI_FIFO_ADDR_SIZE = 9.
- Sub-module: one instance of the existing ram block.
  - ADDR_SIZE and DATA_SIZE are passed through.
  - wclk and rclk are both tied to clk.
- Pointer, count and handshake logic live in midi_byte_fifo itself; there is no further split.

Test Plan:
- Reset and latency: release rst_n; push 0x90 at edge 0 with out_ready=0.
  - in_ready=1 and level=0 after reset.
  - out_valid=1 with out_data=0x90 in cycle 2.
  - level=1 from cycle 1.
- Streaming: push 0x90, 0x3C, 0x7F, 0x80 on consecutive cycles with out_ready=1.
  - The four bytes come out in order on consecutive cycles with no bubble.
  - level ends at 0.
- Fill and overflow: ADDR_SIZE=3 with out_ready=0; push 0x00..0x09.
  - Pushes 0x00..0x08 are accepted: 8 in memory plus 1 head, level=9.
  - in_ready=0 after the 9th; 0x09 is dropped and overflow=1.
  - Draining returns 0x00..0x08.
- Simultaneous push and pop at steady level 4: toggle in_valid and out_ready together for 20 cycles.
  - level stays 4.
  - Output order matches a scoreboard across rd_ptr/wr_ptr wrap.
- Stall stability: head 0xF0 valid with out_ready=0 for 10 cycles while pushing 0x01, 0x02.
  - out_data stays 0xF0.
  - Releasing out_ready then yields 0x01, 0x02.
- Flush and asynchronous reset: with level=5 and overflow=1, pulse flush concurrently with a push.
  - Next cycle: level=0, out_valid=0, overflow=0, and the pushed byte is absent.
  - Repeat with rst_n asserted mid-stream: outputs clear without waiting for a clock edge.

Source files
------------

// File: rtl/midi_byte_fifo_pkg.sv
// Shared MIDI constants used by the MIDI byte FIFO and its storage block.
//
// Contents:
//   MIDI_DATA_SIZE       width of one MIDI byte
//   MIDI_FIFO_ADDR_SIZE  default address width of the port-to-router FIFO
package midi_byte_fifo_pkg;

    localparam int MIDI_DATA_SIZE      = 8;
    localparam int MIDI_FIFO_ADDR_SIZE = 9;

endpackage

// File: rtl/midi_byte_fifo_ram.sv
// Simple dual-port block RAM with a registered, read-enabled read port.
// rdata only changes on a clock edge where re is high, so a stalled reader
// sees a stable word.
//
// Ports:
//   wclk   write clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   rclk   read clock
//   re     read enable
//   raddr  read address
//   rdata  registered read data (one cycle after re)
module midi_byte_fifo_ram
    import midi_byte_fifo_pkg::*;
#(
    parameter int ADDR_SIZE = MIDI_FIFO_ADDR_SIZE,
    parameter int DATA_SIZE = MIDI_DATA_SIZE
) (
    input  logic                 wclk,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic                 rclk,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [DATA_SIZE-1:0] rdata
);

    logic [DATA_SIZE-1:0] mem [0:(1 << ADDR_SIZE)-1];

    always_ff @(posedge wclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge rclk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/midi_byte_fifo.sv
// First-word-fall-through byte FIFO between a MIDI port receiver and the
// router core. Storage is a block RAM with a one-cycle registered read; this
// block keeps the head byte prefetched in the RAM output register so the
// consumer sees it without a request cycle.
//
// Ports:
//   clk        single clock for the FIFO and both RAM ports
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of contents and flags
//   in_data    byte to enqueue
//   in_valid   producer offers in_data
//   in_ready   FIFO can accept (not full)
//   out_data   head byte (RAM read register)
//   out_valid  out_data holds a valid head byte
//   out_ready  consumer takes the head byte
//   level      bytes held, memory plus head
//   overflow   sticky: a push was attempted while full
module midi_byte_fifo
    import midi_byte_fifo_pkg::*;
#(
    parameter int ADDR_SIZE = MIDI_FIFO_ADDR_SIZE,
    parameter int DATA_SIZE = MIDI_DATA_SIZE,
    parameter int RAM_DEPTH = (1 << ADDR_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [DATA_SIZE-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_SIZE:0]   level,
    output logic                 overflow
);

    localparam logic [ADDR_SIZE:0]   FULL_COUNT = (ADDR_SIZE+1)'(RAM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] PTR_ONE    = ADDR_SIZE'(1);
    localparam logic [ADDR_SIZE:0]   COUNT_ONE  = (ADDR_SIZE+1)'(1);

    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    // Bytes still in RAM, not counting the prefetched head.
    logic [ADDR_SIZE:0]   mem_count;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 fetch;
    logic                 ram_we;
    logic                 ram_re;

    assign full     = (mem_count == FULL_COUNT);
    assign in_ready = ~full;
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

    // Refill the head register whenever it is empty or being consumed.
    // Requiring mem_count != 0 also keeps a read away from the address
    // being written into an empty FIFO.
    assign fetch    = (mem_count != '0) & (~out_valid | pop);

    // A flush discards that cycle's transfer; gating the RAM keeps the
    // read register from moving while the state is being cleared.
    assign ram_we   = push & ~flush;
    assign ram_re   = fetch & ~flush;

    assign level    = mem_count + {{ADDR_SIZE{1'b0}}, out_valid};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (fetch) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            case ({push, fetch})
                2'b10:   mem_count <= mem_count + COUNT_ONE;
                2'b01:   mem_count <= mem_count - COUNT_ONE;
                default: mem_count <= mem_count;
            endcase

            if (fetch) begin
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end

            if (in_valid & full) begin
                overflow <= 1'b1;
            end
        end
    end

    midi_byte_fifo_ram #(
        .ADDR_SIZE (ADDR_SIZE),
        .DATA_SIZE (DATA_SIZE)
    ) u_ram (
        .wclk  (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (in_data),
        .rclk  (clk),
        .re    (ram_re),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_midi_byte_fifo.sv
// Self-checking bench for midi_byte_fifo, built with a small 8-deep RAM so
// fill, overflow and pointer wrap are reached in a few cycles. A queue-based
// model of the FIFO contents is compared against the DUT on every falling
// clock edge; directed checks pin the model with hand-computed values.
module tb_midi_byte_fifo;

    localparam int ADDR_SIZE = 3;
    localparam int DATA_SIZE = 8;
    localparam int DEPTH     = 1 << ADDR_SIZE;

    logic                 clk       = 1'b0;
    logic                 rst_n     = 1'b0;
    logic                 flush     = 1'b0;
    logic [DATA_SIZE-1:0] in_data   = '0;
    logic                 in_valid  = 1'b0;
    logic                 in_ready;
    logic [DATA_SIZE-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [ADDR_SIZE:0]   level;
    logic                 overflow;

    int assertions  = 0;
    int failures    = 0;
    int cycle_count = 0;

    logic [7:0] model_q [$];
    bit         model_head = 1'b0;
    bit         model_ovf  = 1'b0;

    logic [7:0] pop_data  [$];
    int         pop_cycle [$];

    midi_byte_fifo #(
        .ADDR_SIZE (ADDR_SIZE),
        .DATA_SIZE (DATA_SIZE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs; returns 1 time unit after the edge that used them.
    task automatic apply_stimulus(input bit v, input logic [7:0] d, input bit r, input bit f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    // Behavioural model: the FIFO is an ordered queue of held bytes, the
    // first of which is visible once it has been read out of memory.
    initial begin
        int mem_n;
        bit m_push, m_pop, m_fetch;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_q.delete();
                model_head = 1'b0;
                model_ovf  = 1'b0;
            end else begin
                cycle_count++;
                mem_n   = model_q.size() - int'(model_head);
                m_push  = in_valid && (mem_n < DEPTH);
                m_pop   = model_head && out_ready;
                m_fetch = (mem_n > 0) && (!model_head || m_pop);
                if (flush) begin
                    model_q.delete();
                    model_head = 1'b0;
                    model_ovf  = 1'b0;
                end else begin
                    if (in_valid && mem_n >= DEPTH) model_ovf = 1'b1;
                    if (m_pop) void'(model_q.pop_front());
                    if (m_push) model_q.push_back(in_data);
                    if (m_fetch) model_head = 1'b1;
                    else if (m_pop) model_head = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check_output("in_ready", 32'(in_ready), 32'((model_q.size() - int'(model_head)) < DEPTH));
            check_output("level", 32'(level), 32'(model_q.size()));
            check_output("out_valid", 32'(out_valid), 32'(model_head));
            check_output("overflow", 32'(overflow), 32'(model_ovf));
            if (model_head) check_output("out_data", 32'(out_data), 32'(model_q[0]));
            if (rst_n && !flush && out_valid && out_ready) begin
                pop_data.push_back(out_data);
                pop_cycle.push_back(cycle_count);
            end
        end
    end

    initial begin
        logic [7:0] stream_bytes [4];
        logic [7:0] stall_bytes  [3];
        stream_bytes = '{8'h90, 8'h3C, 8'h7F, 8'h80};
        stall_bytes  = '{8'hF0, 8'h01, 8'h02};

        // Reset and first-byte latency
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_output("reset_in_ready", 32'(in_ready), 32'd1);
        check_output("reset_level", 32'(level), 32'd0);
        check_output("reset_out_valid", 32'(out_valid), 32'd0);
        apply_stimulus(1, 8'h90, 0, 0);
        check_output("lat_level_c1", 32'(level), 32'd1);
        check_output("lat_valid_c1", 32'(out_valid), 32'd0);
        apply_stimulus(0, 8'h00, 0, 0);
        check_output("lat_valid_c2", 32'(out_valid), 32'd1);
        check_output("lat_data_c2", 32'(out_data), 32'h90);
        check_output("lat_level_c2", 32'(level), 32'd1);
        apply_stimulus(0, 8'h00, 1, 0);

        // Streaming with no bubbles
        pop_data.delete();
        pop_cycle.delete();
        for (int i = 0; i < 4; i++) apply_stimulus(1, stream_bytes[i], 1, 0);
        repeat (4) apply_stimulus(0, 8'h00, 1, 0);
        check_output("stream_count", 32'(pop_data.size()), 32'd4);
        if (pop_data.size() == 4) begin
            for (int i = 0; i < 4; i++) check_output("stream_data", 32'(pop_data[i]), 32'(stream_bytes[i]));
            for (int i = 1; i < 4; i++) check_output("stream_no_bubble", 32'(pop_cycle[i]), 32'(pop_cycle[i-1] + 1));
        end
        check_output("stream_level_end", 32'(level), 32'd0);

        // Fill to RAM_DEPTH+1 and overflow
        pop_data.delete();
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1, 8'(i), 0, 0);
            if (i == 8) check_output("fill_in_ready_full", 32'(in_ready), 32'd0);
        end
        check_output("fill_level", 32'(level), 32'd9);
        check_output("fill_overflow", 32'(overflow), 32'd1);
        repeat (12) apply_stimulus(0, 8'h00, 1, 0);
        check_output("drain_count", 32'(pop_data.size()), 32'd9);
        if (pop_data.size() == 9) begin
            for (int i = 0; i < 9; i++) check_output("drain_data", 32'(pop_data[i]), 32'(i));
        end

        // Stalled head stays stable
        pop_data.delete();
        apply_stimulus(1, 8'hF0, 0, 0);
        apply_stimulus(0, 8'h00, 0, 0);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(i < 2, 8'(i + 1), 0, 0);
            check_output("stall_data", 32'(out_data), 32'hF0);
        end
        repeat (5) apply_stimulus(0, 8'h00, 1, 0);
        check_output("stall_count", 32'(pop_data.size()), 32'd3);
        if (pop_data.size() == 3) begin
            for (int i = 0; i < 3; i++) check_output("stall_order", 32'(pop_data[i]), 32'(stall_bytes[i]));
        end

        // Steady level 4 with simultaneous push and pop across pointer wrap
        pop_data.delete();
        for (int i = 0; i < 4; i++) apply_stimulus(1, 8'(8'h10 + i), 0, 0);
        check_output("steady_level_start", 32'(level), 32'd4);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus((i % 2) == 0, 8'(8'h20 + i), (i % 2) == 0, 0);
            check_output("steady_level", 32'(level), 32'd4);
        end
        repeat (6) apply_stimulus(0, 8'h00, 1, 0);
        check_output("steady_count", 32'(pop_data.size()), 32'd14);
        if (pop_data.size() == 14) begin
            check_output("steady_first", 32'(pop_data[0]), 32'h10);
            check_output("steady_fifth", 32'(pop_data[4]), 32'h20);
            check_output("steady_last", 32'(pop_data[13]), 32'h32);
        end

        // Flush with a concurrent push; overflow is still set from the fill
        for (int i = 0; i < 5; i++) apply_stimulus(1, 8'(8'h50 + i), 0, 0);
        check_output("pre_flush_level", 32'(level), 32'd5);
        check_output("pre_flush_overflow", 32'(overflow), 32'd1);
        apply_stimulus(1, 8'hEE, 0, 1);
        check_output("flush_level", 32'(level), 32'd0);
        check_output("flush_out_valid", 32'(out_valid), 32'd0);
        check_output("flush_overflow", 32'(overflow), 32'd0);
        check_output("flush_in_ready", 32'(in_ready), 32'd1);
        repeat (3) apply_stimulus(0, 8'h00, 0, 0);
        check_output("flush_byte_absent", 32'(out_valid), 32'd0);
        check_output("flush_level_idle", 32'(level), 32'd0);

        // Asynchronous reset mid-stream, between clock edges
        apply_stimulus(1, 8'h61, 1, 0);
        apply_stimulus(1, 8'h62, 1, 0);
        apply_stimulus(1, 8'h63, 1, 0);
        check_output("pre_reset_valid", 32'(out_valid), 32'd1);
        check_output("pre_reset_level", 32'(level), 32'd2);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_output("async_out_valid", 32'(out_valid), 32'd0);
        check_output("async_level", 32'(level), 32'd0);
        check_output("async_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) apply_stimulus(0, 8'h00, 1, 0);
        check_output("post_reset_level", 32'(level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
